// File: rtl/scanline_renderer_pkg.sv
// Shared scanline renderer types: FSM states, VRAM bases, LCDC bits.
// Window layer is compiled in only when SCANLINE_WINDOW_EN is defined.
package video_types;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_MAP,
    FETCH_LO,
    FETCH_HI,
    PUSH,
    DONE
  } state_t;

  localparam logic [15:0] MAP0_BASE  = 16'h9800;
  localparam logic [15:0] MAP1_BASE  = 16'h9C00;
  localparam logic [15:0] TILE_UBASE = 16'h8000;
  localparam logic [15:0] TILE_SBASE = 16'h9000;

  localparam int LCDC_BG_EN    = 0;
  localparam int LCDC_BG_MAP   = 3;
  localparam int LCDC_TILE_SEL = 4;
  localparam int LCDC_WIN_EN   = 5;
  localparam int LCDC_WIN_MAP  = 6;

  typedef logic [7:0] tile_idx_t;
  typedef logic [1:0] color_t;
  typedef logic [1:0] shade_t;

  function automatic shade_t shade_of(
    input logic [7:0] pal,
    input color_t     c
  );
    logic [7:0] s;
    s = pal >> {c, 1'b0};
    return s[1:0];
  endfunction

endpackage

// File: rtl/scanline_renderer_if.sv
// Pixel stream handshake between the renderer and the LCD sink.
interface scanline_renderer_if;
  import video_types::*;

  logic       pix_valid;
  logic       pix_ready;
  shade_t     pix_shade;
  logic [7:0] pix_x;

  modport master (
    output pix_valid,
    output pix_shade,
    output pix_x,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_shade,
    input  pix_x,
    output pix_ready
  );

endinterface

// File: rtl/scanline_renderer_tile_shifter.sv
// Holds one tile row's bitplanes and shifts 2-bit colors out MSB first.
module tile_shifter
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic [2:0] discard,
  output color_t     color,
  output color_t     next_color,
  output logic       last
);

  logic [7:0] lo_q;
  logic [7:0] hi_q;
  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo_q  <= '0;
      hi_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      lo_q  <= lo << discard;
      hi_q  <= hi << discard;
      cnt_q <= 4'd8 - {1'b0, discard};
    end else if (shift && cnt_q != 4'd0) begin
      lo_q  <= lo_q << 1;
      hi_q  <= hi_q << 1;
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign color      = {hi_q[7], lo_q[7]};
  assign next_color = {hi_q[6], lo_q[6]};
  assign last       = (cnt_q == 4'd1);

endmodule

// File: rtl/scanline_renderer.sv
// Tile-based background scanline renderer with a valid/ready pixel stream.
// Define SCANLINE_WINDOW_EN to compile in the window layer.
module scanline_renderer
  import video_types::*;
#(
  parameter int LINE_WIDTH = 160,
  parameter int NUM_LINES  = 144,
  parameter int MAP_DIM    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  ly,
  input  logic [7:0]  lcdc,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  bgp,
  input  logic [7:0]  wx,
  input  logic [7:0]  wy,
  output logic        vram_rd,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_data,
  scanline_renderer_if.master pix,
  output logic        busy,
  output logic        line_done
);

  localparam int MW = $clog2(MAP_DIM);
  localparam logic [7:0] LAST_X = 8'(LINE_WIDTH - 1);

  state_t      state;
  logic [1:0]  ph;
  logic [7:0]  line_y_q;
  logic [2:0]  scx_lo_q;
  logic [MW-1:0] mapcol_q;
  logic        bg_map_q;
  logic        tile_sel_q;
  logic        blank_q;
  logic [7:0]  bgp_q;
  tile_idx_t   idx_q;
  logic [7:0]  lo_q;
  logic        first_q;

  logic        in_win;
  logic        hit_now;
  logic        hit_next;
  logic [7:0]  fetch_y;
  logic        map_sel;
  logic [15:0] map_base;
  logic [15:0] map_addr;
  logic [15:0] tile_base;
  logic [15:0] row_addr;

  logic        sh_load;
  logic        sh_shift;
  logic [2:0]  sh_discard;
  color_t      sh_color;
  color_t      sh_next;
  logic        sh_last;

`ifdef SCANLINE_WINDOW_EN
  logic       in_win_q;
  logic       win_line_q;
  logic       win_map_q;
  logic [7:0] wstart_q;
  logic [7:0] win_y_q;
  logic [7:0] win_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_win_q   <= 1'b0;
      win_line_q <= 1'b0;
      win_map_q  <= 1'b0;
      wstart_q   <= '0;
      win_y_q    <= '0;
      win_cnt_q  <= '0;
    end else if (state == IDLE && line_start) begin
      in_win_q   <= 1'b0;
      win_line_q <= lcdc[LCDC_WIN_EN] && ly >= wy
                    && wx <= 8'd166;
      wstart_q   <= (wx < 8'd7) ? 8'd0 : wx - 8'd7;
      win_map_q  <= lcdc[LCDC_WIN_MAP];
      win_y_q    <= (ly == 8'd0) ? 8'd0 : win_cnt_q;
      if (ly == 8'd0)
        win_cnt_q <= '0;
    end else if (state == PUSH && !pix.pix_valid && hit_now) begin
      in_win_q <= 1'b1;
    end else if (state == DONE && in_win_q) begin
      win_cnt_q <= win_cnt_q + 8'd1;
    end
  end

  assign in_win   = in_win_q;
  assign hit_now  = win_line_q && !in_win_q && !blank_q
                    && pix.pix_x == wstart_q;
  assign hit_next = win_line_q && !in_win_q && !blank_q
                    && pix.pix_x + 8'd1 == wstart_q;
  assign fetch_y  = in_win_q ? win_y_q : line_y_q;
  assign map_sel  = in_win_q ? win_map_q : bg_map_q;

  logic unused;
  assign unused = ^{lcdc[7], lcdc[2:1], NUM_LINES > 0};
`else
  assign in_win   = 1'b0;
  assign hit_now  = 1'b0;
  assign hit_next = 1'b0;
  assign fetch_y  = line_y_q;
  assign map_sel  = bg_map_q;

  logic unused;
  assign unused = ^{lcdc[7:5], lcdc[2:1], wx, wy,
                    NUM_LINES > 0};
`endif

  assign map_base  = map_sel ? MAP1_BASE : MAP0_BASE;
  assign map_addr  = map_base
                     + ({11'd0, fetch_y[7:3]} << MW)
                     + 16'(mapcol_q);
  // 8000h mode indexes unsigned, 9000h mode signed
  assign tile_base = tile_sel_q
                     ? TILE_UBASE + {4'd0, idx_q, 4'd0}
                     : TILE_SBASE + {{4{idx_q[7]}}, idx_q, 4'd0};
  assign row_addr  = tile_base + {12'd0, fetch_y[2:0], 1'b0};

  assign sh_load    = (state == FETCH_HI) && (ph == 2'd2);
  assign sh_shift   = (state == PUSH) && pix.pix_valid
                      && pix.pix_ready;
  assign sh_discard = (first_q && !in_win) ? scx_lo_q : 3'd0;

  tile_shifter u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .shift      (sh_shift),
    .lo         (lo_q),
    .hi         (vram_data),
    .discard    (sh_discard),
    .color      (sh_color),
    .next_color (sh_next),
    .last       (sh_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ph            <= '0;
      busy          <= 1'b0;
      line_done     <= 1'b0;
      vram_rd       <= 1'b0;
      vram_addr     <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_shade <= '0;
      pix.pix_x     <= '0;
      line_y_q      <= '0;
      scx_lo_q      <= '0;
      mapcol_q      <= '0;
      bg_map_q      <= 1'b0;
      tile_sel_q    <= 1'b0;
      blank_q       <= 1'b0;
      bgp_q         <= '0;
      idx_q         <= '0;
      lo_q          <= '0;
      first_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (line_start) begin
          busy          <= 1'b1;
          line_y_q      <= ly + scy;
          scx_lo_q      <= scx[2:0];
          mapcol_q      <= MW'(scx >> 3);
          bg_map_q      <= lcdc[LCDC_BG_MAP];
          tile_sel_q    <= lcdc[LCDC_TILE_SEL];
          blank_q       <= !lcdc[LCDC_BG_EN];
          bgp_q         <= bgp;
          first_q       <= 1'b1;
          ph            <= '0;
          pix.pix_x     <= '0;
          pix.pix_valid <= 1'b0;
          state <= lcdc[LCDC_BG_EN] ? FETCH_MAP : PUSH;
        end
        FETCH_MAP, FETCH_LO, FETCH_HI: begin
          // issue, wait for data, capture
          unique case (ph)
            2'd0: begin
              vram_rd <= 1'b1;
              ph      <= 2'd1;
              unique case (1'b1)
                state == FETCH_MAP: vram_addr <= map_addr;
                state == FETCH_LO:  vram_addr <= row_addr;
                default: vram_addr <= row_addr + 16'd1;
              endcase
            end
            2'd1: begin
              vram_rd <= 1'b0;
              ph      <= 2'd2;
            end
            default: begin
              ph <= 2'd0;
              unique case (1'b1)
                state == FETCH_MAP: begin
                  idx_q <= vram_data;
                  state <= FETCH_LO;
                end
                state == FETCH_LO: begin
                  lo_q  <= vram_data;
                  state <= FETCH_HI;
                end
                default: begin
                  first_q <= 1'b0;
                  state   <= PUSH;
                end
              endcase
            end
          endcase
        end
        PUSH: begin
          if (!pix.pix_valid) begin
            if (hit_now) begin
              mapcol_q <= '0;
              state    <= FETCH_MAP;
            end else begin
              pix.pix_valid <= 1'b1;
              pix.pix_shade <= shade_of(bgp_q,
                blank_q ? 2'd0 : sh_color);
            end
          end else if (pix.pix_ready) begin
            if (pix.pix_x == LAST_X) begin
              pix.pix_valid <= 1'b0;
              line_done     <= 1'b1;
              state         <= DONE;
            end else begin
              pix.pix_x <= pix.pix_x + 8'd1;
              if (!blank_q && sh_last) begin
                pix.pix_valid <= 1'b0;
                mapcol_q      <= mapcol_q + 1'b1;
                state         <= FETCH_MAP;
              end else if (hit_next) begin
                pix.pix_valid <= 1'b0;
              end else begin
                pix.pix_shade <= shade_of(bgp_q,
                  blank_q ? 2'd0 : sh_next);
              end
            end
          end
        end
        DONE: begin
          line_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scanline_renderer.sv
// Directed bench for scanline_renderer: fetch addresses, pixel stream,
// fine scroll, signed tiles, backpressure, blanking and mid-line reset.
module tb_scanline_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  ly, lcdc, scx, scy, bgp, wx, wy;
  logic        vram_rd;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic        busy;
  logic        line_done;

  scanline_renderer_if pif();

  scanline_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .ly         (ly),
    .lcdc       (lcdc),
    .scx        (scx),
    .scy        (scy),
    .bgp        (bgp),
    .wx         (wx),
    .wy         (wy),
    .vram_rd    (vram_rd),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .pix        (pif),
    .busy       (busy),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];

  always @(posedge clk)
    if (vram_rd) vram_data <= mem[vram_addr];

  int n_chk = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_done = 0;
  logic [15:0] addr_q [$];
  logic [1:0]  sh_got [$];
  logic [7:0]  x_got [$];
  logic [1:0]  exp_sh [160];
  logic [1:0]  t2 [8] = '{2'd0, 2'd0, 2'd2, 2'd2,
                          2'd1, 2'd1, 2'd3, 2'd3};

  always @(negedge clk) begin
    if (vram_rd) begin
      n_rd++;
      addr_q.push_back(vram_addr);
    end
    if (line_done) n_done++;
    if (pif.pix_valid && pif.pix_ready) begin
      sh_got.push_back(pif.pix_shade);
      x_got.push_back(pif.pix_x);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log;
    n_rd = 0;
    n_done = 0;
    addr_q.delete();
    sh_got.delete();
    x_got.delete();
  endtask

  task automatic start(input logic [7:0] l, c, sx, sy, p);
    ly = l;
    lcdc = c;
    scx = sx;
    scy = sy;
    bgp = p;
    line_start = 1'b1;
    step(1);
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 4000 && n_done == 0; i++) step(1);
    step(3);
    check({tag, "_done"}, n_done, 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_x(input string tag, input logic [7:0] x);
    for (int i = 0; i < 2000
         && !(pif.pix_valid && pif.pix_x == x); i++)
      step(1);
    check({tag, "_reach"},
          32'(pif.pix_valid && pif.pix_x == x), 1);
  endtask

  // tile 1 (all color 1) at map col 0, tile 2 at col 1, zeros after
  task automatic set_exp(input int sx);
    int p;
    for (int x = 0; x < 160; x++) begin
      p = x + sx;
      if (p < 8) exp_sh[x] = 2'd1;
      else if (p < 16) exp_sh[x] = t2[p-8];
      else exp_sh[x] = 2'd0;
    end
  endtask

  task automatic fill_exp(input logic [1:0] s);
    for (int x = 0; x < 160; x++) exp_sh[x] = s;
  endtask

  task automatic cmp_line(input string tag);
    int bs = 0;
    int bx = 0;
    check({tag, "_count"}, sh_got.size(), 160);
    for (int i = 0; i < sh_got.size() && i < 160; i++) begin
      if (sh_got[i] !== exp_sh[i]) bs++;
      if (x_got[i] !== 8'(i)) bx++;
    end
    check({tag, "_shade_bad"}, bs, 0);
    check({tag, "_x_bad"}, bx, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h9800] = 8'h01;
    mem[16'h9801] = 8'h02;
    mem[16'h8010] = 8'hFF;
    mem[16'h8011] = 8'h00;
    mem[16'h8020] = 8'h0F;
    mem[16'h8021] = 8'h33;

    reset = 1'b1;
    line_start = 1'b0;
    ly = 0; lcdc = 0; scx = 0; scy = 0;
    bgp = 0; wx = 0; wy = 0;
    pif.pix_ready = 1'b1;
    step(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(line_done), 0);
    check("rst_rd", 32'(vram_rd), 0);
    check("rst_valid", 32'(pif.pix_valid), 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_x", 32'(pif.pix_x), 0);
    check("rst_shade", 32'(pif.pix_shade), 0);
    reset = 1'b0;
    step(2);

    // basic line, no scroll
    set_exp(0);
    clear_log();
    start(8'd0, 8'h91, 8'd0, 8'd0, 8'hE4);
    check("t1_busy_set", 32'(busy), 1);
    wait_done("t1");
    check("t1_addr0", 32'(addr_q[0]), 32'h9800);
    check("t1_addr1", 32'(addr_q[1]), 32'h8010);
    check("t1_addr2", 32'(addr_q[2]), 32'h8011);
    check("t1_addr3", 32'(addr_q[3]), 32'h9801);
    check("t1_nrd", n_rd, 60);
    cmp_line("t1");

    // fine scroll discards 3 leading pixels
    set_exp(3);
    clear_log();
    start(8'd0, 8'h91, 8'd3, 8'd0, 8'hE4);
    wait_done("t2");
    check("t2_nrd", n_rd, 63);
    check("t2_sh4", 32'(sh_got[4]), 1);
    check("t2_sh5", 32'(sh_got[5]), 0);
    check("t2_sh7", 32'(sh_got[7]), 2);
    cmp_line("t2");

    // signed tile addressing from 9000h
    mem[16'h9800] = 8'h80;
    mem[16'h8804] = 8'hAA;
    mem[16'h8805] = 8'h55;
    clear_log();
    start(8'd2, 8'h81, 8'd0, 8'd0, 8'hE4);
    wait_done("t3");
    check("t3_addr1", 32'(addr_q[1]), 32'h8804);
    check("t3_addr2", 32'(addr_q[2]), 32'h8805);
    check("t3_addr4", 32'(addr_q[4]), 32'h9024);
    check("t3_sh0", 32'(sh_got[0]), 1);
    check("t3_sh1", 32'(sh_got[1]), 2);
    check("t3_sh8", 32'(sh_got[8]), 0);
    mem[16'h9800] = 8'h01;

    // backpressure, plus a line_start while busy
    set_exp(0);
    clear_log();
    start(8'd0, 8'h91, 8'd0, 8'd0, 8'hE4);
    step(20);
    ly = 8'd8;
    scx = 8'd5;
    line_start = 1'b1;
    step(1);
    line_start = 1'b0;
    wait_x("t4", 8'd10);
    pif.pix_ready = 1'b0;
    repeat (5) begin
      step(1);
      check("t4_hold_valid", 32'(pif.pix_valid), 1);
      check("t4_hold_x", 32'(pif.pix_x), 10);
      check("t4_hold_shade", 32'(pif.pix_shade), 2);
    end
    pif.pix_ready = 1'b1;
    wait_done("t4");
    cmp_line("t4");

    // background disabled
    fill_exp(2'd3);
    clear_log();
    start(8'd0, 8'h00, 8'd0, 8'd0, 8'h03);
    wait_done("t5");
    check("t5_nrd", n_rd, 0);
    cmp_line("t5");

    // reset mid-line
    set_exp(0);
    clear_log();
    start(8'd0, 8'h91, 8'd0, 8'd0, 8'hE4);
    wait_x("t6", 8'd50);
    reset = 1'b1;
    #1;
    check("t6_valid", 32'(pif.pix_valid), 0);
    check("t6_x", 32'(pif.pix_x), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_rd", 32'(vram_rd), 0);
    check("t6_shade", 32'(pif.pix_shade), 0);
    step(2);
    reset = 1'b0;
    step(2);
    check("t6_nodone", n_done, 0);
    clear_log();
    start(8'd0, 8'h91, 8'd0, 8'd0, 8'hE4);
    wait_done("t6b");
    cmp_line("t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
